// File: rtl/branch_pkg.sv
// Shared RV32I branch condition encodings used by the branch datapath.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational comparator: equality, signed less-than and unsigned less-than.
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_eq,
  output logic            o_lt_s,
  output logic            o_lt_u
);

  logic [XLEN-1:0] w_a_bias;
  logic [XLEN-1:0] w_b_bias;

  // Flipping the MSB maps two's complement order onto unsigned order.
  assign w_a_bias = {~i_a[XLEN-1], i_a[XLEN-2:0]};
  assign w_b_bias = {~i_b[XLEN-1], i_b[XLEN-2:0]};

  assign o_eq   = (i_a == i_b);
  assign o_lt_u = (i_a < i_b);
  assign o_lt_s = (w_a_bias < w_b_bias);

endmodule

// File: rtl/branch_unit.sv
// Branch condition decode with a combinational decision and a one-cycle
// registered copy of decision, illegal flag and branch target.
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [2:0]      funct3,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            result,
  output logic            illegal,
  output logic            result_q,
  output logic            illegal_q,
  output logic            valid_q,
  output logic [XLEN-1:0] target_q
);

  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_result;
  logic            w_illegal;
  logic [XLEN-1:0] w_target;

  logic            r_result;
  logic            r_illegal;
  logic            r_valid;
  logic [XLEN-1:0] r_target;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .i_a    (in1),
    .i_b    (in2),
    .o_eq   (w_eq),
    .o_lt_s (w_lt_s),
    .o_lt_u (w_lt_u)
  );

  always_comb begin
    w_result  = 1'b0;
    w_illegal = 1'b0;
    case (funct3)
      BR_BEQ:  w_result = w_eq;
      BR_BNE:  w_result = ~w_eq;
      BR_BLT:  w_result = w_lt_s;
      BR_BGE:  w_result = ~w_lt_s;
      BR_BLTU: w_result = w_lt_u;
      BR_BGEU: w_result = ~w_lt_u;
      default: begin
        w_result  = 1'b0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Carry out of the address add is dropped so the target wraps.
  assign w_target = pc + imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= 1'b0;
      r_illegal <= 1'b0;
      r_valid   <= 1'b0;
      r_target  <= '0;
    end else if (valid_i) begin
      r_result  <= w_result;
      r_illegal <= w_illegal;
      r_valid   <= 1'b1;
      r_target  <= w_target;
    end else begin
      r_result  <= 1'b0;
      r_illegal <= 1'b0;
      r_valid   <= 1'b0;
    end
  end

  assign result    = w_result;
  assign illegal   = w_illegal;
  assign result_q  = r_result;
  assign illegal_q = r_illegal;
  assign valid_q   = r_valid;
  assign target_q  = r_target;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: vector table, random sweep against a
// reference model, and hand-written pipeline/reset sequences.
module tb_branch_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [2:0]      funct3;
  logic            valid_i;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            result;
  logic            illegal;
  logic            result_q;
  logic            illegal_q;
  logic            valid_q;
  logic [XLEN-1:0] target_q;

  branch_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in2       (in2),
    .funct3    (funct3),
    .valid_i   (valid_i),
    .pc        (pc),
    .imm       (imm),
    .result    (result),
    .illegal   (illegal),
    .result_q  (result_q),
    .illegal_q (illegal_q),
    .valid_q   (valid_q),
    .target_q  (target_q)
  );

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            exp_res;
    logic            exp_ill;
  } vec_t;

  typedef struct {
    logic            res;
    logic            ill;
    logic            vld;
    logic [XLEN-1:0] tgt;
  } exp_t;

  vec_t vecs[22];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [XLEN-1:0] last_tgt;

  localparam logic [XLEN-1:0] ONES = 32'hFFFF_FFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic ref_res(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one valid operation, check the combinational outputs, queue the registered expectation.
  task automatic drive(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic v, input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                       input logic er, input logic ei, input string name);
    exp_t e;
    @(negedge clk);
    funct3 = f; in1 = a; in2 = b; valid_i = v; pc = p; imm = im;
    #1;
    chk({name, ".result"}, {31'd0, result}, {31'd0, er});
    chk({name, ".illegal"}, {31'd0, illegal}, {31'd0, ei});
    e.vld = v;
    e.res = v ? er : 1'b0;
    e.ill = v ? ei : 1'b0;
    e.tgt = v ? (p + im) : last_tgt;
    last_tgt = e.tgt;
    sb.push_back(e);
  endtask

  task automatic collect(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.scoreboard: actual=empty required=entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".valid_q"}, {31'd0, valid_q}, {31'd0, e.vld});
      chk({name, ".result_q"}, {31'd0, result_q}, {31'd0, e.res});
      chk({name, ".illegal_q"}, {31'd0, illegal_q}, {31'd0, e.ill});
      chk({name, ".target_q"}, target_q, e.tgt);
    end
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'd0, 32'd0, 1'b1, 1'b0};
    vecs[1]  = '{3'b001, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[2]  = '{3'b000, 32'd0, ONES,  1'b0, 1'b0};
    vecs[3]  = '{3'b001, 32'd0, ONES,  1'b1, 1'b0};
    vecs[4]  = '{3'b100, 32'd0, ONES,  1'b0, 1'b0};
    vecs[5]  = '{3'b101, 32'd0, ONES,  1'b1, 1'b0};
    vecs[6]  = '{3'b100, ONES,  32'd0, 1'b1, 1'b0};
    vecs[7]  = '{3'b101, ONES,  32'd0, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, ONES,  ONES,  1'b0, 1'b0};
    vecs[9]  = '{3'b101, ONES,  ONES,  1'b1, 1'b0};
    vecs[10] = '{3'b110, 32'd0, ONES,  1'b1, 1'b0};
    vecs[11] = '{3'b111, 32'd0, ONES,  1'b0, 1'b0};
    vecs[12] = '{3'b110, ONES,  32'd0, 1'b0, 1'b0};
    vecs[13] = '{3'b111, ONES,  32'd0, 1'b1, 1'b0};
    vecs[14] = '{3'b110, 32'd0, 32'd0, 1'b0, 1'b0};
    vecs[15] = '{3'b111, 32'd0, 32'd0, 1'b1, 1'b0};
    vecs[16] = '{3'b010, 32'd5, 32'd5, 1'b0, 1'b1};
    vecs[17] = '{3'b011, 32'd0, ONES,  1'b0, 1'b1};
    vecs[18] = '{3'b010, ONES,  32'd3, 1'b0, 1'b1};
    vecs[19] = '{3'b011, 32'd7, 32'd7, 1'b0, 1'b1};
    vecs[20] = '{3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0};
    vecs[21] = '{3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0};

    rst_n = 1'b0; valid_i = 1'b0; funct3 = 3'b000;
    in1 = '0; in2 = '0; pc = '0; imm = '0;
    last_tgt = '0;
    #12;
    chk("reset.valid_q", {31'd0, valid_q}, 32'd0);
    chk("reset.result_q", {31'd0, result_q}, 32'd0);
    chk("reset.illegal_q", {31'd0, illegal_q}, 32'd0);
    chk("reset.target_q", target_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b1, $urandom, $urandom,
            vecs[i].exp_res, vecs[i].exp_ill, $sformatf("vec%0d", i));
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]      f;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic            v;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      v = ($urandom_range(0, 4) != 0);
      drive(f, a, b, v, $urandom, $urandom, ref_res(f, a, b), (f == 3'b010) || (f == 3'b011),
            $sformatf("rnd%0d", i));
      collect($sformatf("rnd%0d", i));
    end

    // Wrapping target on the registered path.
    drive(3'b000, 32'h1234, 32'h1234, 1'b1, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b0, "wrap");
    collect("wrap");
    chk("wrap.target_const", target_q, 32'h0000_0010);

    // Idle cycle clears flags and holds the previous target.
    drive(3'b001, 32'd1, 32'd2, 1'b0, 32'hAAAA_0000, 32'h5555, 1'b1, 1'b0, "idle");
    collect("idle");

    // Capture, then assert reset between edges.
    drive(3'b000, 32'd9, 32'd9, 1'b1, 32'h100, 32'h8, 1'b1, 1'b0, "prerst");
    collect("prerst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid_q", {31'd0, valid_q}, 32'd0);
    chk("midrst.result_q", {31'd0, result_q}, 32'd0);
    chk("midrst.target_q", target_q, 32'd0);
    chk("midrst.result_eq", {31'd0, result}, 32'd1);
    in2 = 32'd8;
    #1;
    chk("midrst.result_track", {31'd0, result}, 32'd0);
    funct3 = 3'b011;
    #1;
    chk("midrst.illegal_track", {31'd0, illegal}, 32'd1);
    funct3 = 3'b000; valid_i = 1'b1;
    @(posedge clk);
    #1;
    chk("inrst.valid_q", {31'd0, valid_q}, 32'd0);
    chk("inrst.target_q", target_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_tgt = '0;
    drive(3'b101, 32'd3, 32'd3, 1'b1, 32'h40, 32'h4, 1'b1, 1'b0, "postrst");
    collect("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
